genius_sequence_player: RTL and testbench

GENIUS_SEQUENCE_PLAYER -- requirements
Module: genius_sequence_player

---
 rtl/genius_sequence_player.sv | 136 +++++++++++++
 tb/tb_genius_sequence_player.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_sequence_player.sv
// genius_sequence_player: plays a stored colour sequence on four LEDs.
// Each step fetches one colour from an external memory and shows it for
// SLOW_ON or FAST_ON cycles, then keeps the LEDs dark for GAP cycles.
// Optional feature macro: GENIUS_PLAYER_ABORT_EN adds an 'abort' input
// that ends a run early without a done pulse.
module genius_sequence_player #(
    parameter int ADDR_W  = 5,
    parameter int SLOW_ON = 8,
    parameter int FAST_ON = 4,
    parameter int GAP     = 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              speed,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_rdata,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
`ifdef GENIUS_PLAYER_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int MAX_ON = (SLOW_ON > FAST_ON) ? SLOW_ON : FAST_ON;
    localparam int MAX_CNT = (MAX_ON > GAP) ? MAX_ON : GAP;
    localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_ON - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_ON - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [CNT_W-1:0]  on_last;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        color;
    logic [ADDR_W:0]   idx_inc;

    // One bit wider than the index so seq_len = 2^ADDR_W is reachable without wrap
    assign idx_inc = {1'b0, idx} + (ADDR_W + 1)'(1);

    // Moore outputs decoded from the registered state
    assign mem_rd = (state == S_FETCH);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign led    = (state == S_ON) ? color : '0;

    // Playback sequencer: state, step index, latched run settings and timers
    always_ff @(posedge clk) begin
        if (rst_) begin
            state    <= S_IDLE;
            idx      <= '0;
            len_q    <= '0;
            on_last  <= '0;
            cnt      <= '0;
            color    <= '0;
            mem_addr <= '0;
        end
`ifdef GENIUS_PLAYER_ABORT_EN
        else if (abort && state != S_IDLE && state != S_DONE) begin
            state <= S_IDLE;
            cnt   <= '0;
        end
`endif
        else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= seq_len;
                        on_last <= speed ? FAST_LAST : SLOW_LAST;
                        idx     <= '0;
                        cnt     <= '0;
                        if (seq_len != '0) begin
                            mem_addr <= '0;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    color <= mem_rdata;
                    cnt   <= '0;
                    state <= S_ON;
                end
                S_ON: begin
                    if (cnt == on_last) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (idx_inc == len_q) begin
                            state <= S_DONE;
                        end else begin
                            idx      <= idx_inc[ADDR_W-1:0];
                            mem_addr <= idx_inc[ADDR_W-1:0];
                            state    <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_sequence_player.sv
// Testbench for genius_sequence_player (default parameters).
// Expected behaviour is a per-cycle timeline assembled from the step
// structure: read, wait, show colour, dark gap, then one done cycle.
`timescale 1ns/1ps
module tb_genius_sequence_player;

    localparam int AW   = 5;
    localparam int SLOW = 8;
    localparam int FAST = 4;
    localparam int GP   = 2;

    logic          clk = 1'b0;
    logic          rst_;
    logic          start;
    logic [AW:0]   seq_len;
    logic          speed;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_rdata = 4'h0;
    logic [3:0]    led;
    logic          busy;
    logic          done;
`ifdef GENIUS_PLAYER_ABORT_EN
    logic          abort;
`endif

    genius_sequence_player #(
        .ADDR_W (AW),
        .SLOW_ON(SLOW),
        .FAST_ON(FAST),
        .GAP    (GP)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .start    (start),
        .seq_len  (seq_len),
        .speed    (speed),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .led      (led),
        .busy     (busy),
        .done     (done)
`ifdef GENIUS_PLAYER_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    always #5 clk = ~clk;

    // Sequence memory with one cycle of read latency
    logic [3:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [3:0]    led;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        int len;
        bit spd;
        int xs;       // cycle of an extra (ignored) start pulse, 0 = none
        int chg;      // cycle where seq_len/speed inputs are disturbed, 0 = none
        int done_c;   // expected done cycle
        int reads;    // expected number of read strobes
    } vec_t;

    obs_t          exp_q[$];
    logic [AW-1:0] last_addr;
    int            n_chk  = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample();
        return {mem_rd, mem_addr, led, busy, done};
    endfunction

    task automatic fill_mem;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    // Timeline model: cycles 1.. after the start cycle, plus two idle cycles
    task automatic build(input int len, input bit spd);
        int on;
        logic [AW-1:0] a;
        on = spd ? FAST : SLOW;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            a = AW'(k);
            exp_q.push_back({1'b1, a, 4'h0, 1'b1, 1'b0});
            exp_q.push_back({1'b0, a, 4'h0, 1'b1, 1'b0});
            for (int j = 0; j < on; j++) exp_q.push_back({1'b0, a, mem[k], 1'b1, 1'b0});
            for (int j = 0; j < GP; j++) exp_q.push_back({1'b0, a, 4'h0, 1'b1, 1'b0});
            last_addr = a;
        end
        exp_q.push_back({1'b0, last_addr, 4'h0, 1'b1, 1'b1});
        for (int j = 0; j < 2; j++) exp_q.push_back({1'b0, last_addr, 4'h0, 1'b0, 1'b0});
    endtask

    task automatic play(input string nm, input int len, input bit spd, input int xs,
                        input int chg, input int exp_done, input int exp_reads);
        int   got_done;
        int   reads;
        obs_t o;
        got_done = -1;
        reads    = 0;
        build(len, spd);
        seq_len = (AW+1)'(len);
        speed   = spd;
        start   = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick;
            start = (i + 1 == xs);
            if (i + 1 == chg) begin
                seq_len = (AW+1)'(2);
                speed   = ~spd;
            end
            o = sample();
            chk({nm, " trace"}, {20'b0, o}, {20'b0, exp_q[i]});
            if (o.rd) reads++;
            if (o.done && got_done < 0) got_done = i + 1;
        end
        start = 1'b0;
        if (exp_done >= 0) begin
            chk({nm, " done cycle"}, got_done, exp_done);
            chk({nm, " read count"}, reads, exp_reads);
        end
    endtask

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_    = 1'b1;
        start   = 1'b0;
        seq_len = '0;
        speed   = 1'b0;
`ifdef GENIUS_PLAYER_ABORT_EN
        abort   = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'h0;
        tick;
        tick;
        chk("reset outputs", {20'b0, sample()}, 32'h0);
        rst_      = 1'b0;
        last_addr = '0;

        tbl[0] = '{3,  1'b1, 0, 0,   25,  3};
        tbl[1] = '{0,  1'b0, 1, 0,   1,   0};
        tbl[2] = '{1,  1'b0, 5, 0,   13,  1};
        tbl[3] = '{32, 1'b1, 0, 100, 257, 32};
        tbl[4] = '{2,  1'b0, 7, 3,   25,  2};
        tbl[5] = '{5,  1'b1, 0, 0,   41,  5};

        for (int t = 0; t < 6; t++) begin
            fill_mem();
            if (t == 0) begin
                mem[0] = 4'b0001;
                mem[1] = 4'b0100;
                mem[2] = 4'b1000;
            end
            play($sformatf("vec%0d", t), tbl[t].len, tbl[t].spd, tbl[t].xs,
                 tbl[t].chg, tbl[t].done_c, tbl[t].reads);
        end

        for (int r = 0; r < 10; r++) begin
            fill_mem();
            play($sformatf("rand%0d", r), $urandom_range(0, 32), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 20), $urandom_range(0, 30), -1, -1);
        end

        // Reset during ON of step 1 aborts with no done, then replays from 0
        fill_mem();
        seq_len = (AW+1)'(3);
        speed   = 1'b1;
        start   = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        chk("pre-reset led step1", {28'b0, led}, {28'b0, mem[1]});
        rst_ = 1'b1;
        tick;
        rst_ = 1'b0;
        chk("post-reset led", {28'b0, led}, 32'h0);
        chk("post-reset busy", {31'b0, busy}, 32'h0);
        chk("post-reset mem_addr", {27'b0, mem_addr}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("post-reset quiet", {29'b0, busy, done, mem_rd}, 32'h0);
        end
        last_addr = '0;
        play("replay after reset", 3, 1'b1, 0, 0, 25, 3);

        // start coinciding with reset is ignored
        rst_    = 1'b1;
        start   = 1'b1;
        seq_len = (AW+1)'(3);
        tick;
        rst_  = 1'b0;
        start = 1'b0;
        chk("start in reset busy", {31'b0, busy}, 32'h0);
        tick;
        chk("start in reset idle", {30'b0, busy, mem_rd}, 32'h0);
        last_addr = '0;

`ifdef GENIUS_PLAYER_ABORT_EN
        // Abort in cycle 12 of the three-step run
        mem[0] = 4'b0001;
        mem[1] = 4'b0100;
        mem[2] = 4'b1000;
        seq_len = (AW+1)'(3);
        speed   = 1'b1;
        start   = 1'b1;
        tick;
        start = 1'b0;
        repeat (11) tick;
        chk("abort pre led", {28'b0, led}, 32'h4);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'h0);
        chk("abort led", {28'b0, led}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("abort quiet", {29'b0, busy, done, mem_rd}, 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
